// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core stream loader and its result drain.
// Element index helpers map a linear row-major beat index onto matrix coordinates.
package tensor_core_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DIM        = 4;
    localparam int unsigned ELEMS      = DIM * DIM;
    localparam int unsigned ELEM_W     = $clog2(ELEMS);
    localparam int unsigned ROW_W      = $clog2(DIM);
    localparam int unsigned IDX_W      = ELEM_W + 1;

    typedef logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] matrix_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } loader_state_t;

    function automatic logic [ROW_W-1:0] elem_row(input logic [ELEM_W-1:0] e);
        return ROW_W'(e / ELEM_W'(DIM));
    endfunction

    function automatic logic [ROW_W-1:0] elem_col(input logic [ELEM_W-1:0] e);
        return ROW_W'(e % ELEM_W'(DIM));
    endfunction

endpackage

// File: rtl/tensor_core_result_drain.sv
// Snapshots the core result on capture and serialises it row-major over valid/ready.
// last_beat_c_o flags the cycle in which the final beat handshakes.
module tensor_core_result_drain
    import tensor_core_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  matrix_t               result_i,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic                  last_beat_c_o
);

    matrix_t                 snap_q, snap_d;
    logic [ELEM_W-1:0]       idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    handshake_c;
    logic [ELEM_W-1:0]       idx_next_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Output byte is preloaded one beat ahead so it stays stable while stalled.
    always_comb begin
        snap_d      = snap_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        data_d      = data_q;
        handshake_c = valid_q && out_ready_i;
        idx_next_c  = idx_q + ELEM_W'(1);
        last_beat_c_o = handshake_c && (idx_q == ELEM_W'(ELEMS - 1));

        if (capture_i) begin
            snap_d  = result_i;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = result_i[0][0];
        end else if (handshake_c) begin
            if (last_beat_c_o) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d  = idx_next_c;
                data_d = snap_q[elem_row(idx_next_c)][elem_col(idx_next_c)];
            end
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/tensor_core_stream_loader.sv
// Streams two operand matrices into the tensor core, starts it, waits for completion
// (with a sticky timeout error) and hands the result to the drain serializer.
module tensor_core_stream_loader
    import tensor_core_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 128
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output matrix_t               tensor_core_input1,
    output matrix_t               tensor_core_input2,
    output logic                  tensor_core_register_file_write_enable,
    input  matrix_t               tensor_core_output,
    input  logic                  is_done_with_calculation,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

    loader_state_t        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    matrix_t              a_q, a_d;
    matrix_t              b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 error_q, error_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 we_q, we_d;
    logic                 accept_c;
    logic                 capture_c;
    logic                 last_beat_c;
    logic [ELEM_W-1:0]    elem_c;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        capture_c = 1'b0;
        accept_c  = in_valid && in_ready_q && (state_q == LOAD);
        elem_c    = idx_q[ELEM_W-1:0];

        case (state_q)
            LOAD: begin
                if (accept_c) begin
                    if (idx_q < IDX_W'(ELEMS)) begin
                        a_d[elem_row(elem_c)][elem_col(elem_c)] = in_data;
                    end else begin
                        b_d[elem_row(elem_c)][elem_col(elem_c)] = in_data;
                    end
                    if (idx_q == IDX_W'(2 * ELEMS - 1)) begin
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done on the first WAIT cycle may be stale from the previous run.
                if ((cnt_q != '0) && is_done_with_calculation) begin
                    capture_c = 1'b1;
                    state_d   = DRAIN;
                end else if (cnt_q == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                if (last_beat_c) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = LOAD;
            end
        endcase

        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != LOAD);
        we_d       = (state_d == START);
    end

    tensor_core_result_drain u_drain (
        .clk_i         (clock_in),
        .rst_i         (reset_in),
        .capture_i     (capture_c),
        .result_i      (tensor_core_output),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .last_beat_c_o (last_beat_c)
    );

    assign in_ready                               = in_ready_q;
    assign busy                                   = busy_q;
    assign error                                  = error_q;
    assign tensor_core_register_file_write_enable = we_q;
    assign tensor_core_input1                     = a_q;
    assign tensor_core_input2                     = b_q;

endmodule

// File: tb/tb_tensor_core_stream_loader.sv
// Table-driven bench for the stream loader with a behavioural 4x4 tensor core model;
// directed sequences cover stale done, timeout, and reset mid-WAIT / mid-DRAIN.
module tb_tensor_core_stream_loader;
    import tensor_core_pkg::*;

    localparam int unsigned CORE_LAT = 64;

    typedef struct packed {
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        logic [15:0][7:0] exp;
        logic             gaps;
        logic             stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    matrix_t     in1, in2, core_res;
    logic        we;
    logic        done;
    logic        busy;
    logic        error;

    logic        core_stub = 1'b0;
    logic        late_clear = 1'b0;
    logic        core_done;
    logic        core_busy;
    int unsigned core_cnt;
    int unsigned we_count = 0;

    int checks = 0;
    int errors = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    tensor_core_stream_loader dut (
        .clock_in                               (clk),
        .reset_in                               (reset_in),
        .in_data                                (in_data),
        .in_valid                               (in_valid),
        .in_ready                               (in_ready),
        .out_data                               (out_data),
        .out_valid                              (out_valid),
        .out_ready                              (out_ready),
        .tensor_core_input1                     (in1),
        .tensor_core_input2                     (in2),
        .tensor_core_register_file_write_enable (we),
        .tensor_core_output                     (core_res),
        .is_done_with_calculation               (done),
        .busy                                   (busy),
        .error                                  (error)
    );

    function automatic matrix_t matmul(input matrix_t a, input matrix_t b);
        matrix_t r;
        logic [7:0] acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc + 8'(a[i][k] * b[k][j]);
                r[i][j] = acc;
            end
        end
        return r;
    endfunction

    // Behavioural core: clears done on the start pulse (or one cycle late), result after CORE_LAT.
    always @(posedge clk) begin
        if (reset_in) begin
            core_done <= 1'b0;
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_res  <= '0;
        end else if (we) begin
            core_busy <= 1'b1;
            core_cnt  <= 0;
            if (!late_clear) core_done <= 1'b0;
        end else if (core_busy) begin
            core_done <= (core_cnt == CORE_LAT - 1);
            if (core_cnt == CORE_LAT - 1) begin
                core_busy <= 1'b0;
                core_res  <= matmul(in1, in2);
            end
            core_cnt <= core_cnt + 1;
        end
    end

    always @(posedge clk) if (we) we_count <= we_count + 1;

    assign done = core_stub ? 1'b0 : core_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input vec_t v);
        int guard;
        for (int k = 0; k < 32; k++) begin
            if (v.gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                tick();
            end
            in_data  = (k < 16) ? v.a[k] : v.b[k-16];
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) chk("in_ready_timeout", 32'(guard), 32'd0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk({tag, "_out_valid_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic drain_vec(input vec_t v, input string tag);
        int k = 0;
        int cyc = 0;
        while (k < 16 && cyc < 200) begin
            out_ready = v.stall ? (cyc % 3 == 0) : 1'b1;
            chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk({tag, "_beat"}, 32'(out_data), 32'(v.exp[k]));
                if (out_ready) k++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (k < 16) chk({tag, "_drain_timeout"}, 32'(k), 32'd16);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input logic exp_err);
        int unsigned we_base = we_count;
        send_vec(v);
        chk({tag, "_busy_after_load"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_after_load"}, 32'(in_ready), 32'd0);
        wait_out_valid(tag);
        chk({tag, "_operand_a"}, 32'(in1 === matrix_t'(v.a)), 32'd1);
        chk({tag, "_operand_b"}, 32'(in2 === matrix_t'(v.b)), 32'd1);
        drain_vec(v, tag);
        chk({tag, "_out_valid_end"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_end"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_error_end"}, 32'(error), 32'(exp_err));
        chk({tag, "_we_pulses"}, we_count - we_base, 32'd1);
    endtask

    task automatic pulse_reset();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    initial begin
        vec_t v;
        int n;
        logic saw_valid;

        // Hand-computed vectors: identity*B = B; 2*3*4 = 0x18; 0xFF*0xFF*4 mod 256 = 0x04.
        for (int k = 0; k < 16; k++) begin
            vecs[0].a[k] = (k / 4 == k % 4) ? 8'h01 : 8'h00;
            vecs[0].b[k] = 8'(k);
            vecs[0].exp[k] = 8'(k);
            vecs[1].a[k] = 8'h02;
            vecs[1].b[k] = 8'h03;
            vecs[1].exp[k] = 8'h18;
            vecs[2].a[k] = 8'hFF;
            vecs[2].b[k] = 8'hFF;
            vecs[2].exp[k] = 8'h04;
            vecs[5].a[k] = 8'(k);
            vecs[5].b[k] = (k / 4 == k % 4) ? 8'h01 : 8'h00;
            vecs[5].exp[k] = 8'(k);
        end
        vecs[0].gaps = 1'b0; vecs[0].stall = 1'b0;
        vecs[1].gaps = 1'b0; vecs[1].stall = 1'b0;
        vecs[2].gaps = 1'b0; vecs[2].stall = 1'b0;
        vecs[3] = vecs[2];   vecs[3].gaps = 1'b1;
        vecs[4] = vecs[0];   vecs[4].stall = 1'b1;
        vecs[5].gaps = 1'b1; vecs[5].stall = 1'b1;

        reset_in  = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_in = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_operands_zero", 32'((in1 === '0) && (in2 === '0)), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Stale done still high on the first WAIT cycle must not end WAIT.
        late_clear = 1'b1;
        run_vec(vecs[1], "stale_done", 1'b0);
        late_clear = 1'b0;

        // Timeout: 1 START cycle + 128 WAIT cycles after the last accept edge.
        core_stub = 1'b1;
        send_vec(vecs[0]);
        n = 0;
        saw_valid = 1'b0;
        while (!error && n < 300) begin
            tick();
            n++;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("timeout_cycles", 32'(n), 32'd129);
        chk("timeout_no_drain", 32'(saw_valid), 32'd0);
        chk("timeout_in_ready", 32'(in_ready), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        core_stub = 1'b0;
        run_vec(vecs[1], "error_sticky", 1'b1);

        // Reset mid-WAIT clears error and returns to LOAD.
        send_vec(vecs[2]);
        for (int i = 0; i < 10; i++) tick();
        chk("midwait_busy", 32'(busy), 32'd1);
        pulse_reset();
        chk("midwait_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midwait_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midwait_rst_busy", 32'(busy), 32'd0);
        chk("midwait_rst_error", 32'(error), 32'd0);
        for (int i = 0; i < 100; i++) tick();
        chk("midwait_no_ghost", 32'(out_valid), 32'd0);
        run_vec(vecs[5], "after_midwait", 1'b0);

        // Reset mid-DRAIN with the consumer stalled.
        send_vec(vecs[1]);
        wait_out_valid("middrain");
        for (int i = 0; i < 3; i++) tick();
        chk("middrain_hold", 32'(out_data), 32'h18);
        pulse_reset();
        chk("middrain_rst_in_ready", 32'(in_ready), 32'd1);
        chk("middrain_rst_out_valid", 32'(out_valid), 32'd0);
        chk("middrain_rst_out_data", 32'(out_data), 32'd0);
        run_vec(vecs[0], "after_middrain", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "bench did not terminate");
    end

endmodule
